// File: rtl/shiftreg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shiftreg_ctrl_pkg
//  Brief    : Shared state encoding and length clamp for the shift-register
//             sequencer.
//  Revision : 1.0
// ============================================================================
package shiftreg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shiftreg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : shiftreg_sequencer_if
//  Brief    : Command valid/ready channel into the shift-register sequencer.
//  Revision : 1.0
// ============================================================================
interface shiftreg_sequencer_if #(
    parameter int SHIFT_WIDTH = 8,
    parameter int CNT_W       = $clog2(SHIFT_WIDTH + 1)
) ();
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_clr;
    logic [SHIFT_WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0]       cmd_len;

    modport master (output cmd_valid, cmd_clr, cmd_data, cmd_len, input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_clr, cmd_data, cmd_len, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/shiftreg_shift_counter.sv
`default_nettype none
// ============================================================================
//  Module   : shiftreg_shift_counter
//  Brief    : Loadable down-counter tracking remaining shift cycles.
//  Revision : 1.0
// ============================================================================
module shiftreg_shift_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             is_last
);
    logic [CNT_W-1:0] r_count;

    // Saturates at zero so a stray decrement can never wrap.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count   = r_count;
    assign is_last = (r_count == CNT_W'(1));
endmodule
`default_nettype wire

// File: rtl/shiftreg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shiftreg_sequencer
//  Brief    : Accepts load/clear commands and strobes a shift register through
//             load, shift and clear sequences with a done pulse.
//  Revision : 1.0
// ============================================================================
module shiftreg_sequencer
    import shiftreg_ctrl_pkg::*;
#(
    parameter int SHIFT_WIDTH = 8,
    parameter int CNT_W       = $clog2(SHIFT_WIDTH + 1)
) (
    input  logic                   clock,
    input  logic                   aclr,
    shiftreg_sequencer_if.slave    cmd,
    input  logic                   abort,
    output logic [SHIFT_WIDTH-1:0] sr_data,
    output logic                   sr_load,
    output logic                   sr_enable,
    output logic                   sr_sclr,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       shifts_left
);
    state_t                 r_state;
    state_t                 w_next;
    logic [SHIFT_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]       r_len;
    logic                   w_xfer;
    logic                   w_cnt_load;
    logic                   w_cnt_dec;
    logic [CNT_W-1:0]       w_count;
    logic                   w_is_last;

    assign w_xfer     = cmd.cmd_valid && (r_state == IDLE);
    assign w_cnt_load = (r_state == LOAD);
    assign w_cnt_dec  = (r_state == SHIFT);

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_data <= '0;
            r_len  <= '0;
        end else if (w_xfer) begin
            r_data <= cmd.cmd_data;
            r_len  <= CNT_W'(clamp_len(32'(cmd.cmd_len), SHIFT_WIDTH));
        end
    end

    shiftreg_shift_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock      (clock),
        .aclr       (aclr),
        .load       (w_cnt_load),
        .load_value (r_len),
        .dec        (w_cnt_dec),
        .count      (w_count),
        .is_last    (w_is_last)
    );

    // Abort takes priority over the normal LOAD/SHIFT exits.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cmd.cmd_valid) w_next = cmd.cmd_clr ? CLEAR : LOAD;
            LOAD:    if (abort) w_next = CLEAR;
                     else       w_next = (r_len == '0) ? DONE : SHIFT;
            SHIFT:   if (abort) w_next = CLEAR;
                     else if (w_is_last) w_next = DONE;
            CLEAR:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        sr_load     = 1'b0;
        sr_enable   = 1'b0;
        sr_sclr     = 1'b0;
        done        = 1'b0;
        shifts_left = '0;
        busy        = (r_state != IDLE);
        case (r_state)
            LOAD: begin
                sr_load   = 1'b1;
                sr_enable = 1'b1;
            end
            SHIFT: begin
                sr_enable   = 1'b1;
                shifts_left = w_count;
            end
            CLEAR:   sr_sclr = 1'b1;
            DONE:    done    = 1'b1;
            default: ;
        endcase
    end

    assign cmd.cmd_ready = (r_state == IDLE);
    assign sr_data       = r_data;
endmodule
`default_nettype wire

// File: tb/tb_shiftreg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shiftreg_sequencer
//  Brief    : Self-checking bench: command table, corner sequences and a
//             randomized run against a per-cycle trace model.
//  Revision : 1.0
// ============================================================================
module tb_shiftreg_sequencer;
    localparam int SW = 8;
    localparam int CW = 4;

    logic          clock;
    logic          aclr;
    logic          abort;
    logic [SW-1:0] sr_data;
    logic          sr_load, sr_enable, sr_sclr, busy, done;
    logic [CW-1:0] shifts_left;

    int n_vec = 0;
    int n_err = 0;

    shiftreg_sequencer_if #(.SHIFT_WIDTH(SW), .CNT_W(CW)) cmd_if ();

    shiftreg_sequencer #(.SHIFT_WIDTH(SW), .CNT_W(CW)) dut (
        .clock       (clock),
        .aclr        (aclr),
        .cmd         (cmd_if),
        .abort       (abort),
        .sr_data     (sr_data),
        .sr_load     (sr_load),
        .sr_enable   (sr_enable),
        .sr_sclr     (sr_sclr),
        .busy        (busy),
        .done        (done),
        .shifts_left (shifts_left)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs of one cycle: ready,busy,load,enable,sclr,done,left,data
    typedef struct packed {
        logic          ready;
        logic          busy;
        logic          load;
        logic          enable;
        logic          sclr;
        logic          done;
        logic [CW-1:0] left;
        logic [SW-1:0] data;
    } exp_t;

    typedef struct {
        logic          clr;
        logic [SW-1:0] data;
        logic [CW-1:0] len;
        int            n_load;
        int            n_shift;
        int            n_en;
        int            n_sclr;
        int            done_cyc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic ld, logic en, logic sc, logic dn, logic [CW-1:0] lf, logic [SW-1:0] d);
        exp_t e;
        e = '{ready: 1'b0, busy: 1'b1, load: ld, enable: en, sclr: sc, done: dn, left: lf, data: d};
        return e;
    endfunction

    task automatic send(input logic clr, input logic [SW-1:0] data, input logic [CW-1:0] len);
        @(negedge clock);
        chk("ready_before_send", {31'd0, cmd_if.cmd_ready}, 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_clr   = clr;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_len   = len;
        @(posedge clock);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    vec_t  vecs[7];
    exp_t  q[$];
    exp_t  e, a;
    logic [SW-1:0] last_data;

    initial begin
        int n_load, n_shift, n_en, n_sclr, done_c, cnt, seen;
        vecs[0] = '{1'b0, 8'hA5, 4'd3,  1, 3, 4, 0, 5};
        vecs[1] = '{1'b0, 8'h3C, 4'd0,  1, 0, 1, 0, 2};
        vecs[2] = '{1'b0, 8'h5A, 4'd15, 1, 8, 9, 0, 10};
        vecs[3] = '{1'b1, 8'hFF, 4'd4,  0, 0, 0, 1, 2};
        vecs[4] = '{1'b0, 8'h81, 4'd8,  1, 8, 9, 0, 10};
        vecs[5] = '{1'b0, 8'hC3, 4'd9,  1, 8, 9, 0, 10};
        vecs[6] = '{1'b0, 8'h01, 4'd1,  1, 1, 2, 0, 3};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_clr   = 1'b0;
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_len   = '0;
        abort            = 1'b0;
        aclr             = 1'b1;
        #1;
        chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        chk("rst_outs", {26'd0, busy, sr_load, sr_enable, sr_sclr, done, |shifts_left}, 32'd0);
        chk("rst_data", {24'd0, sr_data}, 32'd0);
        @(negedge clock);
        aclr = 1'b0;

        // Table of single commands
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].clr, vecs[v].data, vecs[v].len);
            n_load = 0; n_shift = 0; n_en = 0; n_sclr = 0; done_c = 0;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clock);
                if (sr_load) begin
                    n_load++;
                    chk($sformatf("v%0d_load_data", v), {24'd0, sr_data}, {24'd0, vecs[v].data});
                end
                if (sr_enable) n_en++;
                if (sr_enable && !sr_load) begin
                    n_shift++;
                    chk($sformatf("v%0d_shifts_left", v), {28'd0, shifts_left},
                        32'(vecs[v].n_shift - n_shift + 1));
                end
                if (sr_sclr) begin
                    n_sclr++;
                    chk($sformatf("v%0d_sclr_excl", v), {30'd0, sr_load, sr_enable}, 32'd0);
                end
                if (done) begin
                    done_c = c;
                    break;
                end
            end
            chk($sformatf("v%0d_done_cycle", v), 32'(done_c), 32'(vecs[v].done_cyc));
            chk($sformatf("v%0d_n_load", v),  32'(n_load),  32'(vecs[v].n_load));
            chk($sformatf("v%0d_n_shift", v), 32'(n_shift), 32'(vecs[v].n_shift));
            chk($sformatf("v%0d_n_enable", v), 32'(n_en),   32'(vecs[v].n_en));
            chk($sformatf("v%0d_n_sclr", v),  32'(n_sclr),  32'(vecs[v].n_sclr));
            @(negedge clock);
            chk($sformatf("v%0d_after_done", v), {30'd0, done, cmd_if.cmd_ready}, 32'd1);
        end

        // Asynchronous reset in the middle of a shift sequence
        send(1'b0, 8'h77, 4'd6);
        repeat (3) @(negedge clock);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 aclr = 1'b1;
        #1;
        chk("midrst_outs", {26'd0, busy, sr_load, sr_enable, sr_sclr, done, |shifts_left}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        chk("midrst_data", {24'd0, sr_data}, 32'd0);
        @(negedge clock);
        aclr = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);

        // Abort in 2nd SHIFT cycle while a second command waits on valid
        send(1'b0, 8'h66, 4'd6);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = 8'h99;
        cmd_if.cmd_len   = 4'd2;
        @(negedge clock);
        chk("ab_c1_load", {30'd0, sr_load, cmd_if.cmd_ready}, 32'd2);
        @(negedge clock);
        chk("ab_c2_left", {28'd0, shifts_left}, 32'd6);
        @(negedge clock);
        chk("ab_c3_left", {28'd0, shifts_left}, 32'd5);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("ab_c4_clear", {29'd0, sr_sclr, sr_enable, sr_load}, 32'd4);
        @(negedge clock);
        chk("ab_c5_done", {30'd0, done, cmd_if.cmd_ready}, 32'd2);
        @(negedge clock);
        chk("ab_c6_idle", {30'd0, cmd_if.cmd_ready, busy}, 32'd2);
        @(posedge clock);
        #1 cmd_if.cmd_valid = 1'b0;
        @(negedge clock);
        chk("ab_c7_load", {23'd0, sr_load, sr_data}, {23'd0, 1'b1, 8'h99});
        cnt = 7; done_c = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            cnt++;
            if (done) begin
                done_c = cnt;
                break;
            end
        end
        chk("ab_second_done_cycle", 32'(done_c), 32'd10);

        // Randomized run against the trace model
        @(negedge clock);
        aclr = 1'b1;
        #2 aclr = 1'b0;
        q.delete();
        last_data = '0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            e = (q.size() != 0) ? q[0]
                : exp_t'{ready: 1'b1, busy: 1'b0, load: 1'b0, enable: 1'b0, sclr: 1'b0,
                         done: 1'b0, left: '0, data: last_data};
            a = '{ready: cmd_if.cmd_ready, busy: busy, load: sr_load, enable: sr_enable,
                  sclr: sr_sclr, done: done, left: shifts_left, data: sr_data};
            chk($sformatf("rand_cycle_%0d", i), 32'(a), 32'(e));

            cmd_if.cmd_valid = 1'($urandom_range(0, 1));
            cmd_if.cmd_clr   = ($urandom_range(0, 3) == 0);
            cmd_if.cmd_data  = SW'($urandom);
            cmd_if.cmd_len   = CW'($urandom_range(0, 15));
            abort            = ($urandom_range(0, 9) == 0);

            // Model the coming rising edge
            if (q.size() == 0) begin
                if (cmd_if.cmd_valid) begin
                    int len;
                    last_data = cmd_if.cmd_data;
                    len = (int'(cmd_if.cmd_len) > SW) ? SW : int'(cmd_if.cmd_len);
                    if (cmd_if.cmd_clr) begin
                        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, '0, last_data));
                    end else begin
                        q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, '0, last_data));
                        for (int s = len; s >= 1; s--)
                            q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CW'(s), last_data));
                    end
                    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, '0, last_data));
                end
            end else begin
                exp_t f;
                f = q.pop_front();
                if (abort && f.enable) begin
                    q.delete();
                    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, '0, last_data));
                    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, '0, last_data));
                end
            end
        end
        cmd_if.cmd_valid = 1'b0;
        abort            = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
